ripple_adder: RTL and testbench
===============================

Name: ripple_adder

Overview:
- Parameterised two's-complement ripple-carry adder: sum = a + b + cin, built as an explicit chain of 1-bit full adders, LSB to MSB. No lookahead or prefix logic.
- Result, carry-out and overflow flag are registered once on the output side.
- Reference/baseline adder in the adder comparison set; also usable as a generic datapath adder.

Parameters:
- WIDTH, 32, operand and sum width in bits (legal range 2 or more).

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- a  input  WIDTH  operand A, two's complement or unsigned
- b  input  WIDTH  operand B, two's complement or unsigned
- cin  input  1  carry into bit 0
- sum  output  WIDTH  registered a + b + cin, modulo 2^WIDTH
- cout  output  1  registered carry out of bit WIDTH-1
- of  output  1  registered signed-overflow flag (see Optional Feature)

Behaviour:
- Datapath is combinational:
  - c[0] = cin.
  - For i = 0..WIDTH-1: s[i] = a[i]^b[i]^c[i]; c[i+1] = a[i]&b[i] | a[i]&c[i] | b[i]&c[i].
  - Each stage uses the previous stage's carry (true ripple).
- Registers on each rising clk:
  - rst=1: sum <= 0, cout <= 0, of <= 0. Reset has priority over the inputs.
  - rst=0: sum <= s, cout <= c[WIDTH], of <= ovf_next.
- Latency:
  - Exactly 1 cycle. Inputs sampled at edge N appear on the outputs after edge N.
  - Throughput is one addition per cycle; no handshake, no stall.
- Outputs hold their value between edges. Input changes between edges have no effect until the next edge.
- Reset mid-stream:
  - The result in flight is discarded; outputs read 0 in the cycle after the reset edge.
  - The first post-reset result appears one cycle after rst deasserts.
- Width rules:
  - The full WIDTH+1-bit result is {cout, sum}.
  - Wrap-around is modulo 2^WIDTH. cout reports unsigned carry regardless of operand sign.
- Boundary values (WIDTH=32):
  - 0xFFFFFFFF+0x00000001+0 -> sum 0, cout 1.
  - 0xFFFFFFFF+0xFFFFFFFF+1 -> sum 0xFFFFFFFF, cout 1.
  - 0+0+1 -> sum 1, cout 0.
- No X-propagation masking. Unknown inputs may yield unknown outputs.

Optional Feature:
- Macro: RIPPLE_OVF_DETECT_EN.
- Defined:
  - ovf_next = c[WIDTH] ^ c[WIDTH-1], i.e. signed two's-complement overflow. Equivalent to (a[MSB]==b[MSB]) && (s[MSB]!=a[MSB]).
  - Registered into `of` with the same 1-cycle latency and reset value as the other outputs.
- Undefined (default build):
  - ovf_next is constant 0, so `of` is always 0.
  - No overflow logic is synthesised.
  - The port remains present so the interface is identical in both builds.

Test Plan (WIDTH=32, default build unless noted; check one cycle after applying inputs):
- Reset: assert rst with a=b=0xFFFFFFFF, cin=1 -> sum=0, cout=0, of=0. Deassert rst -> next cycle sum=0xFFFFFFFF, cout=1.
- Signed boundary cases:
  - 0x7FFFFFFF+0x7FFFFFFF, cin=0 -> sum=0xFFFFFFFE, cout=0, of=0.
  - 0x8FFFFFFF+0x8FFFFFFF, cin=0 -> sum=0x1FFFFFFE, cout=1, of=0.
  - Same two cases with RIPPLE_OVF_DETECT_EN defined -> of=1 in both.
- Mixed sign:
  - 0x000007AA+0xFFFFFFFF -> sum=0x000007A9, cout=1, of=0.
  - 0x00000123+0xFFFFF123 -> sum=0xFFFFF246, cout=0.
  - 0xFFFFF999+0x00000111 -> sum=0xFFFFFAAA, cout=0.
  - With RIPPLE_OVF_DETECT_EN defined, of=0 in all three cases.
- Carry-in and negatives:
  - 0xAF+0xAF, cin=1 -> sum=0x0000015F, cout=0.
  - 0xFFFFFFFF+0xFFFFFFFF, cin=0 -> sum=0xFFFFFFFE, cout=1, of=0.
  - 0x0+0xFFFFFFFF -> sum=0xFFFFFFFF, cout=0.
- Full ripple: 0xFFFFFFFF+0x00000000, cin=1 -> sum=0, cout=1. Then apply new inputs on back-to-back cycles -> each result appears exactly one cycle later, no bubbles.

Source files
------------

// File: rtl/ripple_adder.sv
// Parameterised ripple-carry adder: an explicit chain of 1-bit full adders with registered sum, carry-out and overflow.
// Define RIPPLE_OVF_DETECT_EN to enable signed-overflow detection; by default of_o is tied to 0.
module ripple_adder #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             of_o
);

  logic [WIDTH-1:0] sum_d, sum_q;
  logic             cout_d, cout_q;
  logic             of_d, of_q;

  // Carry is a block-local vector so each stage strictly consumes the previous stage's carry.
  always_comb begin : rippleChain
    logic [WIDTH:0] carry;
    carry    = '0;
    sum_d    = '0;
    carry[0] = cin_i;
    for (int i = 0; i < WIDTH; i++) begin
      sum_d[i]   = a_i[i] ^ b_i[i] ^ carry[i];
      carry[i+1] = (a_i[i] & b_i[i]) | (a_i[i] & carry[i]) | (b_i[i] & carry[i]);
    end
    cout_d = carry[WIDTH];
`ifdef RIPPLE_OVF_DETECT_EN
    of_d = carry[WIDTH] ^ carry[WIDTH-1];
`else
    of_d = 1'b0;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
      of_q   <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
      of_q   <= of_d;
    end
  end

  assign sum_o  = sum_q;
  assign cout_o = cout_q;
  assign of_o   = of_q;

endmodule

// File: tb/tb_ripple_adder.sv
// Scoreboard bench for ripple_adder: the driver queues expected results, and a monitor compares them one cycle later.
// Honours RIPPLE_OVF_DETECT_EN when computing the expected overflow flag.
module tb_ripple_adder;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         of;
    string        tag;
  } expT;

  logic         clk;
  logic         rst;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic [W-1:0] sum;
  logic         cout;
  logic         of;

  expT expQ[$];
  int  checks   = 0;
  int  failures = 0;

  ripple_adder #(.WIDTH(W)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .a_i    (a),
    .b_i    (b),
    .cin_i  (cin),
    .sum_o  (sum),
    .cout_o (cout),
    .of_o   (of)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The reference works on integer values rather than on bits, carries or stages.
  function automatic expT model(input logic r, input logic [W-1:0] x, input logic [W-1:0] y,
                                input logic c, input string tag);
    expT    e;
    longint ux, uy, ci, total, sx, sy, sres, maxPos, minNeg;
    e.tag = tag;
    if (r) begin
      e.sum = '0; e.cout = 1'b0; e.of = 1'b0;
      return e;
    end
    ci     = c ? 64'sd1 : 64'sd0;
    ux     = longint'({32'd0, x});
    uy     = longint'({32'd0, y});
    total  = ux + uy + ci;
    e.sum  = total[W-1:0];
    e.cout = (total >= (longint'(1) << W));
    sx     = longint'($signed(x));
    sy     = longint'($signed(y));
    sres   = sx + sy + ci;
    maxPos = (longint'(1) << (W-1)) - 1;
    minNeg = -(longint'(1) << (W-1));
`ifdef RIPPLE_OVF_DETECT_EN
    e.of = (sres > maxPos) || (sres < minNeg);
`else
    e.of = 1'b0;
    if (sres > maxPos || sres < minNeg) e.tag = {tag, "+sovf"};
`endif
    return e;
  endfunction

  task automatic applyStimulus(input logic r, input logic [W-1:0] x, input logic [W-1:0] y,
                               input logic c, input string tag);
    @(negedge clk);
    rst = r; a = x; b = y; cin = c;
    expQ.push_back(model(r, x, y, c, tag));
  endtask

  task automatic checkOutput(input expT e);
    checks++;
    if (sum !== e.sum) begin
      failures++;
      $display("[TB] FAIL %s sum: got %h want %h", e.tag, sum, e.sum);
    end
    checks++;
    if (cout !== e.cout) begin
      failures++;
      $display("[TB] FAIL %s cout: got %b want %b", e.tag, cout, e.cout);
    end
    checks++;
    if (of !== e.of) begin
      failures++;
      $display("[TB] FAIL %s of: got %b want %b", e.tag, of, e.of);
    end
  endtask

  // Each driven cycle has exactly one queued result, which becomes visible just after the following rising edge.
  initial begin : monitor
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) checkOutput(expQ.pop_front());
    end
  end

  // Spec-given results double-check the model itself.
  task automatic checkKnown(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                            input logic [W-1:0] s, input logic co, input string tag);
    expT e;
    e = model(1'b0, x, y, c, tag);
    checks++;
    if (e.sum !== s || e.cout !== co) begin
      failures++;
      $display("[TB] FAIL model-%s: got %h/%b want %h/%b", tag, e.sum, e.cout, s, co);
    end
  endtask

  initial begin : driver
    logic [W-1:0] corners [8];
    logic [W-1:0] x, y;
    corners = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000,
                32'h0000_0001, 32'h8FFF_FFFF, 32'h5555_5555, 32'hAAAA_AAAA};
    rst = 1'b1; a = '0; b = '0; cin = 1'b0;

    checkKnown(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 32'hFFFF_FFFE, 1'b0, "k-pospos");
    checkKnown(32'h8FFF_FFFF, 32'h8FFF_FFFF, 1'b0, 32'h1FFF_FFFE, 1'b1, "k-negneg");
    checkKnown(32'h0000_00AF, 32'h0000_00AF, 1'b1, 32'h0000_015F, 1'b0, "k-cin");

    applyStimulus(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, "reset");
    applyStimulus(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, "reset2");
    applyStimulus(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, "postreset");
    applyStimulus(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, "wrap");
    applyStimulus(1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, "cinonly");
    applyStimulus(1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, "pospos");
    applyStimulus(1'b0, 32'h8FFF_FFFF, 32'h8FFF_FFFF, 1'b0, "negneg");
    applyStimulus(1'b0, 32'h0000_07AA, 32'hFFFF_FFFF, 1'b0, "mixed1");
    applyStimulus(1'b0, 32'h0000_0123, 32'hFFFF_F123, 1'b0, "mixed2");
    applyStimulus(1'b0, 32'hFFFF_F999, 32'h0000_0111, 1'b0, "mixed3");
    applyStimulus(1'b0, 32'h0000_00AF, 32'h0000_00AF, 1'b1, "cinadd");
    applyStimulus(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "negsum");
    applyStimulus(1'b0, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, "zeroneg");
    applyStimulus(1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, "fullripple");
    applyStimulus(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, "minmin");
    applyStimulus(1'b1, 32'h1234_5678, 32'h1111_1111, 1'b1, "midreset");
    applyStimulus(1'b0, 32'h1234_5678, 32'h1111_1111, 1'b1, "afterreset");

    // Back-to-back random traffic with occasional resets and corner operands.
    for (int i = 0; i < 300; i++) begin
      x = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 7)] : $urandom();
      y = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 7)] : $urandom();
      applyStimulus(($urandom_range(0, 19) == 0), x, y, 1'($urandom_range(0, 1)),
                    $sformatf("rand%0d", i));
    end

    // Give the monitor a bounded number of cycles to drain the scoreboard.
    for (int i = 0; i < 10 && expQ.size() > 0; i++) @(negedge clk);
    checks++;
    if (expQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain: got %0d pending want 0", expQ.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
